// File: rtl/water_supply_arbiter.sv
// -----------------------------------------------------------------------------
// water_supply_arbiter
// Round-robin arbiter sharing one mains water inlet between N washing-machine
// controllers. One machine at a time holds the inlet until its drum reports
// full, it withdraws its request, or the per-grant watchdog expires. On expiry
// the machine is flagged in fault_o and left out of arbitration until software
// clears the flag. Every grant is followed by one cycle of valve dead time.
//
// Ports:
//   clk               clock
//   reset             synchronous, active-high reset
//   fill_req_i   [N]  per-machine fill-valve request
//   filled_i     [N]  per-machine drum-full sensor
//   fault_clear_i[N]  per-machine fault clear pulse
//   grant_o      [N]  one-hot (or zero) inlet grant
//   grant_id_o [IDW]  index of granted machine, 0 when none
//   supply_valve_on_o main inlet valve drive (== |grant_o)
//   fault_o      [N]  sticky fill-timeout flags
//   busy_o            high while a grant or its dead time is in progress
//
// State table:
//   S_IDLE    | no grant; arbitrate among eligible requesters
//   S_GRANT   | one machine owns the inlet; watchdog counting
//   S_RELEASE | valve dead time, one cycle with no grant
// -----------------------------------------------------------------------------
module water_supply_arbiter #(
  parameter int N            = 4,
  parameter int FILL_TIMEOUT = 1000,
  parameter int CNT_W        = 10,
  parameter int IDW          = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   fill_req_i,
  input  logic [N-1:0]   filled_i,
  input  logic [N-1:0]   fault_clear_i,
  output logic [N-1:0]   grant_o,
  output logic [IDW-1:0] grant_id_o,
  output logic           supply_valve_on_o,
  output logic [N-1:0]   fault_o,
  output logic           busy_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [N-1:0]   fault_q, fault_d;
  logic [N-1:0]   fault_set;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           valve_q, valve_d;
  logic           busy_q, busy_d;

  logic [N-1:0]   elig;
  logic           found;
  logic [IDW-1:0] pick;
  logic [IDW:0]   idx;
  logic           win_filled, win_req, win_end;

  assign elig = fill_req_i & ~filled_i & ~fault_q;

  // Scan from the pointer upward with wrap; the first eligible machine wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(N)) idx = idx - (IDW+1)'(N);
      if (!found && elig[idx[IDW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IDW-1:0];
      end
    end
  end

  // id_q holds the winner for the whole grant.
  assign win_filled = filled_i[id_q];
  assign win_req    = fill_req_i[id_q];
  assign win_end    = win_filled || !win_req || (cnt_q == CNT_W'(FILL_TIMEOUT-1));

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    valve_d   = valve_q;
    busy_d    = busy_q;
    fault_set = '0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_GRANT;
          grant_d = N'(1) << pick;
          id_d    = pick;
          cnt_d   = '0;
          valve_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_GRANT: begin
        if (cnt_q != CNT_W'(FILL_TIMEOUT)) cnt_d = cnt_q + 1'b1;
        if (win_end) begin
          // Only a still-requesting, still-empty machine is at fault.
          if (!win_filled && win_req) fault_set[id_q] = 1'b1;
          state_d = S_RELEASE;
          grant_d = '0;
          id_d    = '0;
          valve_d = 1'b0;
          ptr_d   = (id_q == IDW'(N-1)) ? '0 : id_q + 1'b1;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        id_d    = '0;
        valve_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Set dominates a simultaneous clear.
    fault_d = (fault_q & ~fault_clear_i) | fault_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      fault_q <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      valve_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      fault_q <= fault_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      valve_q <= valve_d;
      busy_q  <= busy_d;
    end
  end

  assign grant_o           = grant_q;
  assign grant_id_o        = id_q;
  assign supply_valve_on_o = valve_q;
  assign fault_o           = fault_q;
  assign busy_o            = busy_q;

endmodule
